// File: rtl/system_acl_iface_led_pkg.sv
// Shared register map and default widths for the ACL interface LED PWM slave.
package system_acl_iface_led_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_SET      = 3'd1;
    localparam logic [2:0] ADDR_CLEAR    = 3'd2;
    localparam logic [2:0] ADDR_MODE     = 3'd3;
    localparam logic [2:0] ADDR_PRESCALE = 3'd4;
    localparam logic [2:0] ADDR_DUTY     = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    localparam int DEF_WIDTH        = 6;
    localparam int DEF_PRESCALE_W   = 16;
    localparam int DEF_PRESCALE_RST = 49;
    localparam int DEF_DUTY_W       = 8;

endpackage

// File: rtl/system_acl_iface_led_timebase.sv
// Prescaled timebase: down-counting prescaler, PWM/blink counter and blink phase.
module system_acl_iface_led_timebase
    import system_acl_iface_led_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int DUTY_W     = DEF_DUTY_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  reload_i,
    output logic                  tick_o,
    output logic [DUTY_W-1:0]     pwm_cnt_o,
    output logic                  blink_phase_o
);

    logic [PRESCALE_W-1:0] prescCnt_q;
    logic [DUTY_W-1:0]     pwmCnt_q;
    logic                  blinkPhase_q;
    logic                  wrap;

    assign tick_o        = (prescCnt_q == '0);
    assign wrap          = (pwmCnt_q == '1);
    assign pwm_cnt_o     = pwmCnt_q;
    assign blink_phase_o = blinkPhase_q;

    // A reload restarts the period outright and deliberately leaves the blink phase alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescCnt_q   <= '0;
            pwmCnt_q     <= '0;
            blinkPhase_q <= 1'b1;
        end else if (reload_i) begin
            prescCnt_q <= prescale_i;
            pwmCnt_q   <= '0;
        end else if (tick_o) begin
            prescCnt_q <= prescale_i;
            pwmCnt_q   <= pwmCnt_q + DUTY_W'(1);
            if (wrap) begin
                blinkPhase_q <= ~blinkPhase_q;
            end
        end else begin
            prescCnt_q <= prescCnt_q - PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/system_acl_iface_led_pwm.sv
// Avalon-MM LED slave: set/clear data register, per-channel blink and global PWM brightness.
// PWM duty logic is built only when SYSTEM_ACL_IFACE_LED_PWM_EN is defined.
module system_acl_iface_led_pwm
    import system_acl_iface_led_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = PRESCALE_W'(DEF_PRESCALE_RST),
    parameter int DUTY_W     = DEF_DUTY_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                  wrEn;
    logic [WIDTH-1:0]      wdLed;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [WIDTH-1:0]      mode_q, mode_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [WIDTH-1:0]      out_q;
    logic                  reload;
    logic                  tick;
    logic [DUTY_W-1:0]     pwmCnt;
    logic                  blinkPhase;
    logic                  pwmOn;
    logic [31:0]           dutyRd;
    logic [31:0]           pwmCntRd;
    logic                  unusedBits;

    assign wrEn   = chipselect & ~write_n;
    assign wdLed  = writedata[WIDTH-1:0];
    assign reload = wrEn && (address == ADDR_PRESCALE);

    always_comb begin
        data_d     = data_q;
        mode_d     = mode_q;
        prescale_d = prescale_q;
        if (wrEn) begin
            case (address)
                ADDR_DATA:     data_d     = wdLed;
                ADDR_SET:      data_d     = data_q | wdLed;
                ADDR_CLEAR:    data_d     = data_q & ~wdLed;
                ADDR_MODE:     mode_d     = wdLed;
                ADDR_PRESCALE: prescale_d = writedata[PRESCALE_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            mode_q     <= '0;
            prescale_q <= PRESCALE_RST;
        end else begin
            data_q     <= data_d;
            mode_q     <= mode_d;
            prescale_q <= prescale_d;
        end
    end

    // The next-state prescale lets a PRESCALE write load the counter on the same edge.
    system_acl_iface_led_timebase #(
        .PRESCALE_W (PRESCALE_W),
        .DUTY_W     (DUTY_W)
    ) u_timebase (
        .clk           (clk),
        .reset_n       (reset_n),
        .prescale_i    (prescale_d),
        .reload_i      (reload),
        .tick_o        (tick),
        .pwm_cnt_o     (pwmCnt),
        .blink_phase_o (blinkPhase)
    );

`ifdef SYSTEM_ACL_IFACE_LED_PWM_EN
    logic [DUTY_W:0] duty_q, duty_d;

    always_comb begin
        duty_d = duty_q;
        if (wrEn && (address == ADDR_DUTY)) begin
            duty_d = writedata[DUTY_W:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_q <= {1'b1, {DUTY_W{1'b0}}};
        end else begin
            duty_q <= duty_d;
        end
    end

    assign pwmOn      = duty_q[DUTY_W] | (pwmCnt < duty_q[DUTY_W-1:0]);
    assign dutyRd     = 32'(duty_q);
    assign pwmCntRd   = 32'(pwmCnt) << 8;
    assign unusedBits = ^{writedata, tick};
`else
    assign pwmOn      = 1'b1;
    assign dutyRd     = '0;
    assign pwmCntRd   = '0;
    assign unusedBits = ^{writedata, tick, pwmCnt};
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(data_q);
            ADDR_MODE:     readdata = 32'(mode_q);
            ADDR_PRESCALE: readdata = 32'(prescale_q);
            ADDR_DUTY:     readdata = dutyRd;
            ADDR_STATUS:   readdata = pwmCntRd | 32'(blinkPhase);
            default:       readdata = '0;
        endcase
    end

    // Built from pre-edge register values, so a register write shows up one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= data_q & {WIDTH{pwmOn}} & (~mode_q | {WIDTH{blinkPhase}});
        end
    end

    assign out_port = out_q;

endmodule

// File: tb/tb_system_acl_iface_led_pwm.sv
// Self-checking bench for system_acl_iface_led_pwm: directed vector table, corner sequences
// and randomized bus traffic against an arithmetic timebase model.
module tb_system_acl_iface_led_pwm;

`ifdef SYSTEM_ACL_IFACE_LED_PWM_EN
    localparam bit PWM_EN = 1'b1;
`else
    localparam bit PWM_EN = 1'b0;
`endif
    localparam logic [31:0] DUTY_RST = PWM_EN ? 32'h100 : 32'h0;
    localparam logic [31:0] DUTY_ALL = PWM_EN ? 32'h1FF : 32'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [5:0]  out_port;

    int tests = 0;
    int failures = 0;
    logic [31:0] lastRead;

    system_acl_iface_led_pwm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Reference model: registers plus a timebase anchored at the last reset or PRESCALE write.
    logic [5:0] mData, mMode;
    int mPrescale, mDuty;
    int k, k0, p0, w0;
    bit b0;

    function automatic int mTicks();
        int d;
        d = k - k0;
        if (d <= p0) return 0;
        return (d - 1 - p0) / (mPrescale + 1) + 1;
    endfunction

    function automatic int mPwm();
        return (w0 + mTicks()) % 256;
    endfunction

    function automatic bit mPhase();
        return b0 ^ ((((w0 + mTicks()) / 256) % 2) == 1);
    endfunction

    function automatic bit mPwmOn();
        if (!PWM_EN) return 1'b1;
        return (mDuty >= 256) || (mPwm() < (mDuty % 256));
    endfunction

    function automatic logic [5:0] mOut();
        return mData & {6{mPwmOn()}} & (~mMode | {6{mPhase()}});
    endfunction

    function automatic logic [31:0] mRead(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2: return 32'(mData);
            3'd3: return 32'(mMode);
            3'd4: return 32'(mPrescale);
            3'd5: return PWM_EN ? 32'(mDuty) : 32'h0;
            3'd6: return PWM_EN ? ((32'(mPwm()) << 8) | 32'(mPhase())) : 32'(mPhase());
            default: return 32'h0;
        endcase
    endfunction

    function automatic void mReset();
        mData = '0; mMode = '0; mPrescale = 49; mDuty = 256;
        k = 0; k0 = 0; p0 = 0; w0 = 0; b0 = 1'b1;
    endfunction

    function automatic void mEdge(input logic cs, input logic wn, input logic [2:0] a,
                                  input logic [31:0] wd);
        bit ph;
        bit rel;
        ph = mPhase();
        rel = 1'b0;
        if (cs && !wn) begin
            case (a)
                3'd0: mData = wd[5:0];
                3'd1: mData = mData | wd[5:0];
                3'd2: mData = mData & ~wd[5:0];
                3'd3: mMode = wd[5:0];
                3'd4: begin mPrescale = int'(wd[15:0]); rel = 1'b1; end
                3'd5: if (PWM_EN) mDuty = int'(wd[8:0]);
                default: ;
            endcase
        end
        k = k + 1;
        if (rel) begin
            k0 = k; p0 = mPrescale; w0 = 0; b0 = ph;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one bus cycle and checks read data and the resulting out_port.
    task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] a,
                                 input logic [31:0] wd, input bit chkRead,
                                 input logic [31:0] expRead, input bit chkOut,
                                 input logic [5:0] expOut, input string tag);
        logic [5:0] exp;
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        #1;
        lastRead = readdata;
        if (wn) checkOutput("read model", readdata, mRead(a));
        if (chkRead) checkOutput(tag, readdata, expRead);
        exp = mOut();
        mEdge(cs, wn, a, wd);
        @(posedge clk);
        @(negedge clk);
        checkOutput("out model", 32'(out_port), 32'(exp));
        if (chkOut) checkOutput(tag, 32'(out_port), 32'(expOut));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, a, wd, 1'b0, '0, 1'b0, '0, "wr");
    endtask

    task automatic rd(input logic [2:0] a);
        applyStimulus(1'b1, 1'b1, a, '0, 1'b0, '0, 1'b0, '0, "rd");
    endtask

    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [31:0] wd;
        bit          chkRead;
        logic [31:0] expRead;
        bit          chkOut;
        logic [5:0]  expOut;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t rstVecs[$];

    initial begin
        int cnt;
        int lowCnt;
        logic prev;

        vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h0, 1'b1, 32'h0, 1'b1, 6'h00, "rst DATA"});
        vecs.push_back('{1'b1, 1'b1, 3'd3, 32'h0, 1'b1, 32'h0, 1'b1, 6'h00, "rst MODE"});
        vecs.push_back('{1'b1, 1'b1, 3'd4, 32'h0, 1'b1, 32'd49, 1'b1, 6'h00, "rst PRESCALE"});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 32'h0, 1'b1, DUTY_RST, 1'b1, 6'h00, "rst DUTY"});
        vecs.push_back('{1'b1, 1'b1, 3'd7, 32'h0, 1'b1, 32'h0, 1'b0, 6'h00, "rsvd read"});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'h2A, 1'b0, 32'h0, 1'b1, 6'h00, "DATA write latency"});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h0, 1'b1, 32'h2A, 1'b1, 6'h2A, "DATA=2A"});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 32'h01, 1'b0, 32'h0, 1'b1, 6'h2A, "SET edge"});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 32'h08, 1'b0, 32'h0, 1'b1, 6'h2B, "CLEAR edge"});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h0, 1'b1, 32'h23, 1'b1, 6'h23, "DATA=23"});
        vecs.push_back('{1'b1, 1'b1, 3'd1, 32'h0, 1'b1, 32'h23, 1'b1, 6'h23, "SET reads DATA"});
        vecs.push_back('{1'b1, 1'b1, 3'd2, 32'h0, 1'b1, 32'h23, 1'b1, 6'h23, "CLEAR reads DATA"});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 32'hFF, 1'b0, 32'h0, 1'b1, 6'h23, "write without cs"});
        vecs.push_back('{1'b1, 1'b0, 3'd7, 32'hFF, 1'b0, 32'h0, 1'b1, 6'h23, "rsvd write"});
        vecs.push_back('{1'b1, 1'b1, 3'd7, 32'h0, 1'b1, 32'h0, 1'b1, 6'h23, "rsvd reads 0"});
        vecs.push_back('{1'b1, 1'b0, 3'd0, 32'hFFFFFFC1, 1'b0, 32'h0, 1'b1, 6'h23, "DATA wide write"});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 32'h0, 1'b1, 32'h01, 1'b1, 6'h01, "DATA upper masked"});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 6'h01, "MODE write"});
        vecs.push_back('{1'b1, 1'b1, 3'd3, 32'h0, 1'b1, 32'h3F, 1'b1, 6'h01, "MODE masked"});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 32'h0, 1'b0, 32'h0, 1'b0, 6'h00, "MODE clear"});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 6'h00, "DUTY wide write"});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 32'h0, 1'b1, DUTY_ALL, 1'b0, 6'h00, "DUTY masked"});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 32'h100, 1'b0, 32'h0, 1'b0, 6'h00, "DUTY full"});

        rstVecs.push_back('{1'b1, 1'b1, 3'd6, 32'h0, 1'b1, 32'h1, 1'b1, 6'h00, "rst2 STATUS"});
        rstVecs.push_back('{1'b1, 1'b1, 3'd0, 32'h0, 1'b1, 32'h0, 1'b1, 6'h00, "rst2 DATA"});
        rstVecs.push_back('{1'b1, 1'b1, 3'd3, 32'h0, 1'b1, 32'h0, 1'b1, 6'h00, "rst2 MODE"});
        rstVecs.push_back('{1'b1, 1'b1, 3'd4, 32'h0, 1'b1, 32'd49, 1'b1, 6'h00, "rst2 PRESCALE"});
        rstVecs.push_back('{1'b1, 1'b1, 3'd5, 32'h0, 1'b1, DUTY_RST, 1'b1, 6'h00, "rst2 DUTY"});

        repeat (3) @(negedge clk);
        checkOutput("out in reset", 32'(out_port), 32'h0);
        mReset();
        reset_n = 1'b1;

        foreach (vecs[i])
            applyStimulus(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd, vecs[i].chkRead,
                          vecs[i].expRead, vecs[i].chkOut, vecs[i].expOut, vecs[i].name);

        // Brightness: with a tick every clock, one PWM period is 256 clocks.
        wr(3'd4, 32'd0); wr(3'd5, 32'd64); wr(3'd0, 32'h3F); wr(3'd3, 32'h0);
        repeat (4) rd(3'd6);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin rd(3'd6); if (out_port == 6'h3F) cnt++; end
        checkOutput("duty 64 high clocks", 32'(cnt), PWM_EN ? 32'd64 : 32'd256);
        wr(3'd5, 32'd0);
        repeat (4) rd(3'd6);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin rd(3'd6); if (out_port == 6'h3F) cnt++; end
        checkOutput("duty 0 high clocks", 32'(cnt), PWM_EN ? 32'd0 : 32'd256);
        wr(3'd5, 32'h100);
        repeat (4) rd(3'd6);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin rd(3'd6); if (out_port == 6'h3F) cnt++; end
        checkOutput("duty full high clocks", 32'(cnt), 32'd256);

        // Blink on channel 0 only; channel 1 must stay lit.
        wr(3'd3, 32'h01); wr(3'd0, 32'h03);
        rd(3'd6);
        lowCnt = 0;
        prev = out_port[0];
        for (int i = 0; i < 600; i++) begin
            rd(3'd6);
            if (!out_port[1]) lowCnt++;
            if (out_port[0] != prev) begin prev = out_port[0]; break; end
        end
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            rd(3'd6);
            cnt++;
            if (!out_port[1]) lowCnt++;
            if (out_port[0] != prev) break;
        end
        checkOutput("blink half period", 32'(cnt), 32'd256);
        checkOutput("bit1 steady", 32'(lowCnt), 32'd0);

        // PRESCALE write mid-period restarts the PWM counter.
        repeat (37) rd(3'd6);
        wr(3'd4, 32'd3);
        for (int j = 0; j < 12; j++) begin
            rd(3'd6);
            checkOutput("presc reload pwm_cnt", (lastRead >> 8) & 32'hFF,
                        PWM_EN ? 32'(j / 4) : 32'h0);
        end

        // Asynchronous reset in the middle of a PWM period.
        wr(3'd4, 32'd0); wr(3'd3, 32'h0); wr(3'd0, 32'h3F);
        repeat (70) rd(3'd6);
        checkOutput("out before reset", 32'(out_port), 32'h3F);
        #2 reset_n = 1'b0;
        #1 checkOutput("async reset out", 32'(out_port), 32'h0);
        mReset();
        @(negedge clk);
        reset_n = 1'b1;
        foreach (rstVecs[i])
            applyStimulus(rstVecs[i].cs, rstVecs[i].wn, rstVecs[i].addr, rstVecs[i].wd,
                          rstVecs[i].chkRead, rstVecs[i].expRead, rstVecs[i].chkOut,
                          rstVecs[i].expOut, rstVecs[i].name);

        // Randomized bus traffic; small prescale values keep the blink phase moving.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  a;
            logic        cs, wn;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 9) >= 4);
            wd = $urandom;
            if (a == 3'd4) wd = 32'($urandom_range(0, 3));
            applyStimulus(cs, wn, a, wd, 1'b0, '0, 1'b0, '0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
